// File: rtl/board_scan_receiver_if.sv
// Scan-side bus of the board scan receiver.
// The master drives the cell stream and error clear; the slave returns the rebuilt board and status.
interface board_scan_receiver_if;
    logic        scan_en;
    logic [1:0]  xoro_in;
    logic [1:0]  row_in;
    logic [1:0]  col_in;
    logic        err_clr;
    logic [17:0] board;
    logic        board_valid;
    logic        frame_done;
    logic        changed;
    logic [3:0]  new_cell;
    logic        locked;
    logic        seq_err;
    logic        enc_err;
    logic        mono_err;

    modport master (
        output scan_en, xoro_in, row_in, col_in, err_clr,
        input  board, board_valid, frame_done, changed, new_cell,
               locked, seq_err, enc_err, mono_err
    );

    modport slave (
        input  scan_en, xoro_in, row_in, col_in, err_clr,
        output board, board_valid, frame_done, changed, new_cell,
               locked, seq_err, enc_err, mono_err
    );
endinterface

// File: rtl/board_scan_receiver.sv
// Locks onto the chip's repeating nine-cell board scan and rebuilds a shadow board,
// reporting frame commits, board changes and protocol violations.
module board_scan_receiver #(
    parameter int CHECK_MONOTONIC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    board_scan_receiver_if.slave  bus
);
    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t      state, next_state;
    logic [3:0]  exp_idx, next_exp;
    logic [17:0] staging, next_staging;
    logic        bad_frame, next_bad;
    logic [17:0] board, next_board;
    logic        board_valid, next_valid;
    logic        frame_done, next_frame_done;
    logic        changed, next_changed;
    logic [3:0]  new_cell, next_new_cell;
    logic        seq_err, next_seq_err;
    logic        enc_err, next_enc_err;
    logic        mono_err, next_mono_err;

    logic [3:0]  idx;
    logic        invalid;
    logic        illegal;
    logic        accept;
    logic        start;
    logic        brk;
    logic [17:0] staged;
    logic        diff_any;
    logic        mono_hit;
    logic [3:0]  diff_low;

    assign idx     = ({2'b00, bus.row_in} * 4'd3) + {2'b00, bus.col_in};
    assign invalid = (bus.row_in == 2'd3) || (bus.col_in == 2'd3);
    assign illegal = (bus.xoro_in == 2'b11);

    // A valid cell 0 always starts a fresh frame, including the restart after a break.
    always_comb begin
        accept = 1'b0;
        start  = 1'b0;
        brk    = 1'b0;
        if (bus.scan_en) begin
            if (state == HUNT) begin
                if (!invalid && idx == 4'd0) begin
                    accept = 1'b1;
                    start  = 1'b1;
                end
            end else if (!invalid && idx == exp_idx) begin
                accept = 1'b1;
                start  = (idx == 4'd0);
            end else begin
                brk = 1'b1;
                if (!invalid && idx == 4'd0) begin
                    accept = 1'b1;
                    start  = 1'b1;
                end
            end
        end
    end

    // Staging with the current cell written, compared against the committed board.
    always_comb begin
        staged = start ? 18'b0 : staging;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) begin
                staged[2*i +: 2] = bus.xoro_in;
            end
        end
        diff_any = 1'b0;
        diff_low = 4'd0;
        mono_hit = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (staged[2*i +: 2] != board[2*i +: 2]) begin
                diff_any = 1'b1;
                diff_low = 4'(i);
                if (board[2*i +: 2] != 2'b00) begin
                    mono_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state      = state;
        next_exp        = exp_idx;
        next_staging    = staging;
        next_bad        = bad_frame;
        next_board      = board;
        next_valid      = board_valid;
        next_frame_done = 1'b0;
        next_changed    = 1'b0;
        next_new_cell   = new_cell;
        next_seq_err    = seq_err  & ~bus.err_clr;
        next_enc_err    = enc_err  & ~bus.err_clr;
        next_mono_err   = mono_err & ~bus.err_clr;

        if (brk) begin
            next_seq_err = 1'b1;
            if (!accept) begin
                next_state   = HUNT;
                next_exp     = 4'd0;
                next_staging = 18'b0;
                next_bad     = 1'b0;
            end
        end

        if (accept) begin
            next_state   = LOCK;
            next_staging = staged;
            next_bad     = (start ? 1'b0 : bad_frame) | illegal;
            if (illegal) begin
                next_enc_err = 1'b1;
            end
            if (idx == 4'd8) begin
                next_exp = 4'd0;
                // A frame carrying an illegal encoding is scanned through but never committed.
                if (!next_bad) begin
                    next_board      = staged;
                    next_valid      = 1'b1;
                    next_frame_done = 1'b1;
                    next_changed    = diff_any;
                    next_new_cell   = diff_any ? diff_low : 4'd0;
                    if (CHECK_MONOTONIC != 0 && mono_hit) begin
                        next_mono_err = 1'b1;
                    end
                end
            end else begin
                next_exp = idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            exp_idx     <= 4'd0;
            staging     <= 18'b0;
            bad_frame   <= 1'b0;
            board       <= 18'b0;
            board_valid <= 1'b0;
            frame_done  <= 1'b0;
            changed     <= 1'b0;
            new_cell    <= 4'd0;
            seq_err     <= 1'b0;
            enc_err     <= 1'b0;
            mono_err    <= 1'b0;
        end else begin
            state       <= next_state;
            exp_idx     <= next_exp;
            staging     <= next_staging;
            bad_frame   <= next_bad;
            board       <= next_board;
            board_valid <= next_valid;
            frame_done  <= next_frame_done;
            changed     <= next_changed;
            new_cell    <= next_new_cell;
            seq_err     <= next_seq_err;
            enc_err     <= next_enc_err;
            mono_err    <= next_mono_err;
        end
    end

    assign bus.board       = board;
    assign bus.board_valid = board_valid;
    assign bus.frame_done  = frame_done;
    assign bus.changed     = changed;
    assign bus.new_cell    = new_cell;
    assign bus.locked      = (state == LOCK);
    assign bus.seq_err     = seq_err;
    assign bus.enc_err     = enc_err;
    assign bus.mono_err    = mono_err;
endmodule

// File: doc/board_scan_receiver.md
# board_scan_receiver

Host-side receiver for the tic-tac-toe chip's board scan output. The chip repeats a nine-cycle scan of (xoro, row, col), one cell per clock, in row-major order. This block locks onto that scan and rebuilds an 18-bit shadow board from it. It also reports frame completion, board changes and protocol violations, so the test harness or an FPGA companion can track game state without polling internal registers.

## Interface
Parameters:
- CHECK_MONOTONIC, default 1: when 1, flag a committed cell that changes after being non-empty.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  reset, synchronous, active-high.
- scan_en  input  1  sample qualifier; when low, the inputs are ignored and all state holds.
- xoro_in  input  2  cell content: 00 empty, 01 X, 10 O, 11 illegal.
- row_in  input  2  cell row, 0..2; 3 is illegal.
- col_in  input  2  cell column, 0..2; 3 is illegal.
- err_clr  input  1  clears all sticky error flags.
- board  output  18  committed board; cell i = row*3+col occupies bits [2i+1:2i].
- board_valid  output  1  high once the first complete frame has been committed.
- frame_done  output  1  one-cycle pulse on each frame commit.
- changed  output  1  one-cycle pulse with frame_done when the new board differs from the previous one.
- new_cell  output  4  lowest-index cell that differed at the last commit; holds until the next commit.
- locked  output  1  high in the LOCK state.
- seq_err  output  1  sticky: out-of-order or illegal row/col sample while locked.
- enc_err  output  1  sticky: xoro_in = 11 seen.
- mono_err  output  1  sticky: committed non-empty cell changed value (only when CHECK_MONOTONIC = 1).

## Operation
- Index idx = row_in*3 + col_in. A sample is invalid if row_in or col_in is 3.
- State machine has two states, HUNT and LOCK, plus an expected-index counter exp (0..8) and an 18-bit staging register.
- HUNT
  - A qualified sample with idx 0 writes cell 0 to staging, sets exp = 1 and moves to LOCK.
  - Any other sample is discarded without raising an error.
- LOCK, qualified sample with idx == exp:
  - Write xoro_in to staging cell idx; exp increments.
  - If idx == 8: commit staging to board, pulse frame_done, set exp = 0, stay in LOCK.
- LOCK, qualified sample with idx != exp or invalid:
  - Set seq_err and discard staging.
  - If the sample is a valid idx 0: restart capture in the same cycle (cell 0 written, exp = 1, stay in LOCK).
  - Otherwise go to HUNT.
- Encoding errors:
  - xoro_in = 11 sets enc_err and marks the frame bad.
  - A bad frame is not committed at idx 8: no frame_done, board unchanged. The scan still advances and the bad mark clears when the next frame starts.
- Commit comparison is done against the previous board:
  - changed = any cell differs.
  - new_cell = lowest differing index; it is 0 when nothing differs and holds its last value otherwise.
  - If CHECK_MONOTONIC = 1 and any previously non-empty cell differs, set mono_err. The commit still happens.
- Sticky errors clear on err_clr or reset. If a set condition and err_clr occur in the same cycle, the set wins.

## Timing
- All outputs are registered.
- Reset values: board 0, board_valid 0, frame_done 0, changed 0, new_cell 0, locked 0, all error flags 0, state HUNT, exp 0, staging 0.
- Latency: board, frame_done and changed update on the clock edge that samples cell 8, so they are visible in the cycle after cell 8 is presented.
- board_valid rises together with the first frame_done and stays high until reset.
- scan_en low stalls the block: no counter advance, no errors. A stall in the middle of a frame does not break lock.
- Reset in the middle of a frame discards staging immediately. The next frame is captured only from its cell 0.
- Throughput is one cell per qualified clock, so one frame per 9 qualified clocks.

## Test plan
- Clean capture: reset, then scan a board with X at cell 0 and O at cell 4, all others empty, starting at idx 0.
  - Cycle after cell 8: board = 18'h00201, frame_done = 1, changed = 1, new_cell = 0, board_valid = 1, locked = 1.
- Mid-frame lock: start the stream at idx 5.
  - Samples 5..8 are ignored with no seq_err.
  - First frame_done comes 9 cycles after idx 0 appears.
- Sequence break: while locked, present idx 3 where idx 4 is expected.
  - seq_err = 1, locked = 0, no frame_done.
  - Next idx 0 relocks, and the frame after it commits.
- Illegal encoding: xoro_in = 11 at cell 2 of one frame.
  - enc_err = 1, that frame produces no frame_done and board is unchanged.
  - The next clean frame commits normally.
- Monotonic violation: commit a board with cell 0 = X, then a board with cell 0 = O.
  - mono_err = 1, board[1:0] = 10, changed = 1, new_cell = 0.
  - err_clr then returns mono_err to 0.
- Stall: hold scan_en low for 5 cycles after cell 3.
  - No errors and locked stays 1.
  - frame_done arrives 5 cycles later than it would without the stall, and board is correct.
